// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter that shares the read port of an async FIFO among N requesters.
// Defining FIFO_RD_ARB_TIMEOUT_EN adds an empty-stall timeout that aborts a starved burst.
module fifo_rd_arbiter #(
    parameter int N       = 4,
    parameter int DW      = 8,
    parameter int LW      = 3,
    parameter int TIMEOUT = 16
) (
    input  logic            r_clk,
    input  logic            r_rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*LW-1:0] req_len,
    input  logic            r_empty,
    input  logic [DW-1:0]   r_data,
    output logic            r_inc,
    output logic [N-1:0]    gnt,
    output logic [DW-1:0]   rd_data,
    output logic [N-1:0]    rd_valid,
    input  logic [N-1:0]    rd_ready,
    output logic            busy,
    output logic            burst_done,
    output logic            burst_abrt
);
    localparam int PW  = (N > 1) ? $clog2(N) : 1;
    localparam int PW1 = PW + 1;

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [PW-1:0] g_q, g_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pick;
    logic [PW1-1:0] sum;
    logic          found;
    logic          pop;
    logic          timeout_hit;

    // First requester at or after rr_ptr, wrapping explicitly so non-power-of-2 N works.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr_q} + PW1'(k);
            if (sum >= PW1'(N)) sum = sum - PW1'(N);
            if (!found && req[sum[PW-1:0]]) begin
                found = 1'b1;
                pick  = sum[PW-1:0];
            end
        end
    end

    // A pop is suppressed during reset so a burst cut by reset loses no extra word.
    assign pop = (state_q == BURST) && !r_empty && (|(rd_ready & gnt_q)) && r_rst_n;

`ifdef FIFO_RD_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_q, stall_d;
    logic          abrt_q;

    always_comb begin
        stall_d     = '0;
        timeout_hit = 1'b0;
        if (state_q == BURST && r_empty) begin
            stall_d     = stall_q + SW'(1);
            timeout_hit = (stall_d == SW'(TIMEOUT));
        end
    end

    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            stall_q <= '0;
            abrt_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            abrt_q  <= timeout_hit;
        end
    end

    assign burst_abrt = abrt_q;
`else
    assign timeout_hit = 1'b0;
    assign burst_abrt  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        g_d      = g_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BURST;
                    g_d     = pick;
                    gnt_d   = N'(1) << pick;
                    cnt_d   = req_len[int'(pick)*LW +: LW];
                end
            end
            BURST: begin
                if (timeout_hit || (pop && cnt_q == '0)) begin
                    state_d = DONE;
                    gnt_d   = '0;
                end else if (pop) begin
                    cnt_d = cnt_q - LW'(1);
                end
            end
            DONE: begin
                state_d  = IDLE;
                rr_ptr_d = (g_q == PW'(N - 1)) ? '0 : g_q + PW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            g_q      <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            g_q      <= g_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign r_inc      = pop;
    assign gnt        = gnt_q;
    assign rd_data    = r_data;
    assign rd_valid   = (state_q == BURST && !r_empty && r_rst_n) ? gnt_q : '0;
    assign busy       = (state_q != IDLE);
    assign burst_done = (state_q == DONE);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbiter and a queue standing in for the FIFO.
module tb_fifo_rd_arbiter;
    localparam int N       = 4;
    localparam int DW      = 8;
    localparam int LW      = 3;
    localparam int TIMEOUT = 16;
    localparam int LENW    = N * LW;

    logic            r_clk = 1'b0;
    logic            r_rst_n;
    logic [N-1:0]    req;
    logic [LENW-1:0] req_len;
    logic            r_empty;
    logic [DW-1:0]   r_data;
    logic            r_inc;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   rd_data;
    logic [N-1:0]    rd_valid;
    logic [N-1:0]    rd_ready;
    logic            busy;
    logic            burst_done;
    logic            burst_abrt;

    fifo_rd_arbiter #(.N(N), .DW(DW), .LW(LW), .TIMEOUT(TIMEOUT)) dut (
        .r_clk(r_clk), .r_rst_n(r_rst_n), .req(req), .req_len(req_len),
        .r_empty(r_empty), .r_data(r_data), .r_inc(r_inc), .gnt(gnt),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .burst_done(burst_done), .burst_abrt(burst_abrt)
    );

    always #5 r_clk = ~r_clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fifo[$];
    int gq[$];
    int dut_pops;
    logic [N-1:0] prev_gnt;

    // Model: phase 0 = idle, 1 = burst running, 2 = completion cycle.
    int ph, own, left, ptr, stall;
    bit m_abrt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void drive_fifo();
        r_empty = (fifo.size() == 0);
        r_data  = (fifo.size() != 0) ? fifo[0] : DW'($urandom);
    endfunction

    function automatic void push(input int n);
        for (int i = 0; i < n; i++) fifo.push_back(DW'($urandom));
        drive_fifo();
    endfunction

    function automatic void set_len(input int i, input int v);
        req_len[i*LW +: LW] = LW'(v);
    endfunction

    task automatic cycle();
        logic [N-1:0] e_gnt, e_vld;
        logic e_inc;
        bit emp, do_pop;
        int c;
        @(negedge r_clk);
        emp   = (fifo.size() == 0);
        e_gnt = (ph == 1) ? (N'(1) << own) : '0;
        e_inc = (ph == 1) && !emp && rd_ready[own] && (r_rst_n === 1'b1);
        e_vld = (ph == 1 && !emp && r_rst_n === 1'b1) ? e_gnt : '0;
        check("gnt", gnt, e_gnt);
        check("r_inc", r_inc, e_inc);
        check("rd_valid", rd_valid, e_vld);
        check("busy", busy, ph != 0);
        check("burst_done", burst_done, ph == 2);
        check("burst_abrt", burst_abrt, ph == 2 && m_abrt);
        if (!emp) check("rd_data", rd_data, fifo[0]);
        if (r_inc === 1'b1) dut_pops++;
        if (gnt !== '0 && prev_gnt === '0) gq.push_back(int'(gnt));
        prev_gnt = gnt;
        do_pop = e_inc;
        if (r_rst_n !== 1'b1) begin
            ph = 0; ptr = 0; stall = 0; m_abrt = 0; own = 0;
        end else begin
            case (ph)
                0: if (req != '0) begin
                    for (int k = 0; k < N; k++) begin
                        c = (ptr + k) % N;
                        if (req[c]) begin own = c; break; end
                    end
                    left = int'(req_len[own*LW +: LW]) + 1;
                    ph = 1; stall = 0;
                end
                1: begin
                    if (do_pop) begin
                        left--;
                        if (left == 0) ph = 2;
                    end
`ifdef FIFO_RD_ARB_TIMEOUT_EN
                    if (emp) begin
                        stall++;
                        if (stall == TIMEOUT) begin ph = 2; m_abrt = 1; end
                    end else stall = 0;
`endif
                end
                default: begin
                    ptr = (own + 1) % N; ph = 0; m_abrt = 0;
                end
            endcase
        end
        @(posedge r_clk);
        #1;
        if (do_pop) void'(fifo.pop_front());
        drive_fifo();
    endtask

    task automatic do_reset();
        r_rst_n = 1'b0;
        cycle();
        r_rst_n = 1'b1;
    endtask

    initial begin
        ph = 0; own = 0; left = 0; ptr = 0; stall = 0; m_abrt = 0;
        dut_pops = 0; prev_gnt = '0;
        r_rst_n  = 1'b0;
        req      = N'($urandom);
        req_len  = LENW'($urandom);
        rd_ready = N'($urandom);
        push(3);
        @(posedge r_clk);
        #1;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            req = N'($urandom); req_len = LENW'($urandom); rd_ready = N'($urandom);
            cycle();
        end
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", burst_done, 0);
        check("rst_inc", r_inc, 0);
        r_rst_n = 1'b1;

        // Single requester, 4-word burst out of 8
        do_reset();
        fifo.delete(); push(8);
        req = 4'b0010; req_len = '0; set_len(1, 3); rd_ready = '1;
        dut_pops = 0; gq.delete();
        cycle();
        req = '0;
        for (int i = 0; i < 10; i++) cycle();
        check("single_pops", dut_pops, 4);
        check("single_gnt", (gq.size() > 0) ? gq[0] : 0, 2);
        check("single_left", 8 - dut_pops, 4);

        // Round-robin with single-word bursts
        do_reset();
        fifo.delete(); push(16);
        req = '1; req_len = '0; rd_ready = '1;
        dut_pops = 0; gq.delete();
        for (int i = 0; i < 16; i++) cycle();
        for (int k = 0; k < 5; k++)
            check("rr_order", (gq.size() > k) ? gq[k] : 0, 1 << (k % N));
        check("rr_pops", dut_pops, 5);
        req = '0;

        // Empty FIFO and toggling backpressure
        do_reset();
        fifo.delete(); push(2);
        req = 4'b0001; req_len = '0; set_len(0, 7);
        dut_pops = 0;
        for (int i = 0; i < 40; i++) begin
            rd_ready = N'($urandom);
            rd_ready[0] = (i % 2 == 0);
            if (i == 1) req = '0;
            if (i == 5) push(6);
            cycle();
        end
        check("bp_pops", dut_pops, 8);

        // Reset in the middle of a burst
        do_reset();
        fifo.delete(); push(8);
        req = 4'b0100; req_len = '0; set_len(2, 5); rd_ready = '1;
        dut_pops = 0;
        for (int i = 0; i < 20 && dut_pops < 2; i++) begin
            cycle();
            if (i == 0) req = '0;
        end
        check("mrst_prepops", dut_pops, 2);
        r_rst_n = 1'b0;
        cycle();
        r_rst_n = 1'b1;
        #1;
        check("mrst_gnt", gnt, 0);
        check("mrst_busy", busy, 0);
        dut_pops = 0;
        for (int i = 0; i < 3; i++) cycle();
        check("mrst_nopop", dut_pops, 0);
        req = '1; req_len = '0;
        cycle();
        req = '0;
        #1;
        check("mrst_ptr0", gnt, 4'b0001);
        for (int i = 0; i < 4; i++) cycle();

`ifdef FIFO_RD_ARB_TIMEOUT_EN
        begin
            int abrt_seen, both;
            abrt_seen = 0; both = 0;
            do_reset();
            fifo.delete(); push(3);
            req = 4'b0001; req_len = '0; set_len(0, 7); rd_ready = '1;
            dut_pops = 0;
            for (int i = 0; i < 40; i++) begin
                cycle();
                if (i == 0) req = '0;
                #1;
                if (burst_abrt === 1'b1) begin
                    abrt_seen++;
                    if (burst_done === 1'b1) both++;
                end
            end
            check("to_pops", dut_pops, 3);
            check("to_abrt", abrt_seen, 1);
            check("to_both", both, 1);
            req = '1;
            cycle();
            req = '0;
            #1;
            check("to_next", gnt, 4'b0010);
            for (int i = 0; i < 4; i++) cycle();
        end
`endif

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req      = N'($urandom);
            req_len  = LENW'($urandom);
            rd_ready = N'($urandom);
            if ($urandom_range(0, 2) == 0 && fifo.size() < 12) push($urandom_range(1, 4));
            r_rst_n  = ($urandom_range(0, 150) != 0);
            cycle();
        end
        r_rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
